// File: rtl/mux_4x1_rr_if.sv
// Lane-side and consumer-side handshake bundle for the 4:1 round-robin mux.
// master = sources/consumer (testbench side), slave = the mux itself.
interface mux_4x1_rr_if #(
   parameter int unsigned WIDTH = 1
);
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic [WIDTH-1:0] i3;
   logic             v0;
   logic             v1;
   logic             v2;
   logic             v3;
   logic             r0;
   logic             r1;
   logic             r2;
   logic             r3;
   logic [WIDTH-1:0] y;
   logic             s1;
   logic             s0;
   logic             yv;
   logic             yr;

   modport master (
      output i0, i1, i2, i3,
      output v0, v1, v2, v3,
      output yr,
      input  r0, r1, r2, r3,
      input  y, s1, s0, yv
   );

   modport slave (
      input  i0, i1, i2, i3,
      input  v0, v1, v2, v3,
      input  yr,
      output r0, r1, r2, r3,
      output y, s1, s0, yv
   );
endinterface

// File: rtl/mux_4x1_rr.sv
// Four-lane round-robin merge into one registered output word tagged with its lane index.
// Define MUX4X1_FIXED_PRIORITY_EN for fixed priority (lane 0 highest, no rotating pointer).
module mux_4x1_rr #(
   parameter int unsigned WIDTH = 1
) (
   input  logic          clk,
   input  logic          rst,
   mux_4x1_rr_if.slave   io_bus
);

   localparam int unsigned LANES = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_y;
   logic [WIDTH-1:0]   w_y_nxt;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   w_sel_nxt;

   logic [LANES-1:0]   w_valid;
   logic [LANES-1:0]   w_ready;
   logic               w_any_valid;
   logic               w_load;
   logic [SEL_W-1:0]   w_gnt;
   logic [WIDTH-1:0]   w_gnt_data;

   assign w_valid     = {io_bus.v3, io_bus.v2, io_bus.v1, io_bus.v0};
   assign w_any_valid = |w_valid;
   // A word can enter when the register is empty or is being drained this cycle.
   assign w_load      = ((r_state == ST_EMPTY) || io_bus.yr) && w_any_valid;

`ifdef MUX4X1_FIXED_PRIORITY_EN
   // Lowest-numbered valid lane wins.
   always_comb begin : p_arb
      w_gnt = '0;
      for (int j = int'(LANES) - 1; j >= 0; j--) begin
         if (w_valid[SEL_W'(j)]) begin
            w_gnt = SEL_W'(j);
         end
      end
   end
`else
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   w_ptr_nxt;
   logic [SEL_W-1:0]   w_idx;
   logic               w_found;

   // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); first valid lane wins.
   always_comb begin : p_arb
      w_gnt   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int j = 0; j < int'(LANES); j++) begin
         w_idx = r_ptr + SEL_W'(j);
         if (!w_found && w_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   assign w_ptr_nxt = w_load ? (w_gnt + SEL_W'(1)) : r_ptr;

   always_ff @(posedge clk or posedge rst) begin : p_ptr
      if (rst) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end
`endif

   always_comb begin : p_data_mux
      w_gnt_data = io_bus.i0;
      case (w_gnt)
         2'd0:    w_gnt_data = io_bus.i0;
         2'd1:    w_gnt_data = io_bus.i1;
         2'd2:    w_gnt_data = io_bus.i2;
         2'd3:    w_gnt_data = io_bus.i3;
         default: w_gnt_data = io_bus.i0;
      endcase
   end

   // Ready is held low during reset so no source believes it handed off a word.
   assign w_ready   = (w_load && !rst) ? (LANES'(1) << w_gnt) : '0;
   assign io_bus.r0 = w_ready[0];
   assign io_bus.r1 = w_ready[1];
   assign io_bus.r2 = w_ready[2];
   assign io_bus.r3 = w_ready[3];

   always_ff @(posedge clk or posedge rst) begin : p_state
      if (rst) begin
         r_state <= ST_EMPTY;
         r_y     <= '0;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_y     <= w_y_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   always_comb begin : p_next
      w_state_nxt = r_state;
      w_y_nxt     = r_y;
      w_sel_nxt   = r_sel;
      case (r_state)
         ST_EMPTY: begin
            if (w_load) begin
               w_state_nxt = ST_FULL;
               w_y_nxt     = w_gnt_data;
               w_sel_nxt   = w_gnt;
            end
         end
         ST_FULL: begin
            // Drain and refill on the same edge so there is no bubble.
            if (io_bus.yr) begin
               if (w_load) begin
                  w_y_nxt   = w_gnt_data;
                  w_sel_nxt = w_gnt;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
      endcase
   end

   assign io_bus.yv = (r_state == ST_FULL);
   assign io_bus.y  = r_y;
   assign io_bus.s1 = r_sel[1];
   assign io_bus.s0 = r_sel[0];

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Directed bench for mux_4x1_rr: reset, single lane, rotation, backpressure, drain, lane-tag round trip.
module tb_mux_4x1_rr;

   localparam int unsigned W = 8;
`ifdef MUX4X1_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mux_4x1_rr_if #(.WIDTH(W)) bus ();

   mux_4x1_rr #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] rdy();
      return {bus.r3, bus.r2, bus.r1, bus.r0};
   endfunction

   task automatic set_v(input logic [3:0] v);
      bus.v0 = v[0];
      bus.v1 = v[1];
      bus.v2 = v[2];
      bus.v3 = v[3];
   endtask

   task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3);
      bus.i0 = d0;
      bus.i1 = d1;
      bus.i2 = d2;
      bus.i3 = d3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] lane, input logic [W-1:0] data);
      check({tag, "_yv"},  32'(bus.yv), 32'd1);
      check({tag, "_sel"}, 32'({bus.s1, bus.s0}), 32'(lane));
      check({tag, "_y"},   32'(bus.y), 32'(data));
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0] exp_lane;
      logic [1:0] first_lane;
      logic [1:0] second_lane;
      logic [3:0] onehot;

      rst     = 1'b1;
      bus.yr  = 1'b1;
      set_v(4'b0001);
      set_data(8'h30, 8'h31, 8'h32, 8'h33);
      tick();
      tick();
      check("rst_yv",  32'(bus.yv), 32'd0);
      check("rst_y",   32'(bus.y), 32'd0);
      check("rst_sel", 32'({bus.s1, bus.s0}), 32'd0);
      check("rst_rdy", 32'(rdy()), 32'd0);

      // All lanes valid: rotation 0,1,2,3,0,... from ptr=0.
      set_v(4'b1111);
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      rst = 1'b0;
      #1;
      for (int j = 0; j < 8; j++) begin
         exp_lane = FIXED ? 2'd0 : 2'(j);
         check("rot_rdy", 32'(rdy()), 32'(4'b0001 << exp_lane));
         tick();
         chk_out("rot", exp_lane, 8'hA0 + 8'(exp_lane));
      end
      set_v(4'b0000);
      tick();
      check("rot_drain_yv", 32'(bus.yv), 32'd0);

      // Single lane 1 streaming at one word per cycle.
      set_v(4'b0010);
      for (int j = 0; j < 3; j++) begin
         bus.i1 = 8'h11 + 8'(j);
         #1;
         check("one_rdy", 32'(rdy()), 32'b0010);
         tick();
         chk_out("one", 2'd1, 8'h11 + 8'(j));
      end
      set_v(4'b0000);
      tick();
      check("one_drain_yv", 32'(bus.yv), 32'd0);

      // Backpressure: hold lane 2's word while lanes 0 and 3 wait.
      set_data(8'h40, 8'h41, 8'h22, 8'h43);
      set_v(4'b0100);
      tick();
      chk_out("bp_load", 2'd2, 8'h22);
      bus.yr = 1'b0;
      set_v(4'b1001);
      for (int j = 0; j < 3; j++) begin
         #1;
         check("bp_rdy", 32'(rdy()), 32'd0);
         tick();
         chk_out("bp_hold", 2'd2, 8'h22);
      end
      bus.yr      = 1'b1;
      first_lane  = FIXED ? 2'd0 : 2'd3;
      second_lane = FIXED ? 2'd3 : 2'd0;
      #1;
      check("bp_rdy1", 32'(rdy()), 32'(4'b0001 << first_lane));
      tick();
      chk_out("bp_g1", first_lane, (first_lane == 2'd0) ? 8'h40 : 8'h43);
      set_v(4'b0001 << second_lane);
      #1;
      check("bp_rdy2", 32'(rdy()), 32'(4'b0001 << second_lane));
      tick();
      chk_out("bp_g2", second_lane, (second_lane == 2'd0) ? 8'h40 : 8'h43);
      set_v(4'b0000);
      tick();
      check("bp_drain_yv", 32'(bus.yv), 32'd0);

      // Drain leaves ptr at 3; lanes 0 and 1 then both request and lane 0 wins.
      set_v(4'b0100);
      tick();
      chk_out("dr_load", 2'd2, 8'h22);
      set_v(4'b0000);
      tick();
      check("dr_yv", 32'(bus.yv), 32'd0);
      tick();
      check("dr_idle_yv", 32'(bus.yv), 32'd0);
      set_v(4'b0011);
      #1;
      check("dr_rdy", 32'(rdy()), 32'b0001);
      tick();
      chk_out("dr_g", 2'd0, 8'h40);

      // Reset while a word is held and lane 1 is still pending.
      set_v(4'b0010);
      bus.yr = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("mrst_yv",  32'(bus.yv), 32'd0);
      check("mrst_y",   32'(bus.y), 32'd0);
      check("mrst_sel", 32'({bus.s1, bus.s0}), 32'd0);
      check("mrst_rdy", 32'(rdy()), 32'd0);
      set_v(4'b0100);
      bus.yr = 1'b1;
      #1;
      check("mrst_rdy2", 32'(rdy()), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("mrst_rel_rdy", 32'(rdy()), 32'b0100);
      tick();
      chk_out("mrst_out", 2'd2, 8'h22);
      set_v(4'b0000);
      tick();

      // Lane tag decodes back to the originating lane.
      set_data(8'h50, 8'h51, 8'h52, 8'h53);
      for (int k = 0; k < 4; k++) begin
         set_v(4'b0001 << k);
         tick();
         onehot = 4'b0001 << {bus.s1, bus.s0};
         check("rt_onehot", 32'(onehot), 32'(4'b0001 << k));
         check("rt_y", 32'(bus.y), 32'(8'h50 + 8'(k)));
         set_v(4'b0000);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
